// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter that lets N producers share one
// fifo write port. A granted producer may burst up to MAX_BURST words before
// the grant rotates. Writes stall while the fifo reports full, and an external
// overflow indication is latched into a sticky error flag.
// Optional build macro FIFO_WR_ARB_STATS_EN adds a saturating 16-bit
// stall-cycle counter output (stall_cnt).
module fifo_wr_arbiter #(
    parameter int B         = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*B-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    input  logic           fifo_full,
    input  logic           fifo_of,
    input  logic           clr_err,
    output logic           ovf_err,
    output logic [2:0]     owner,
    output logic           busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]    stall_cnt
`endif
);

    typedef enum logic {IDLE, BURST} state_e;

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [2:0]     owner_q;
    logic [2:0]     last_q;
    logic [7:0]     burst_cnt_q;
    logic           ovf_q;

    logic           owner_req;
    logic           accept;
    logic           last_word;
    logic           release_d;
    logic [2:0]     scan_base;
    logic [2:0]     winner_d;
    logic [N-1:0]   win_oh_d;

    // The grant is one-hot, so masking req with it gives the owner's request
    // without indexing by the (possibly wider) owner register.
    always_comb begin
        owner_req = |(req & gnt_q);
        accept    = (state_q == BURST) && owner_req && !fifo_full;
        last_word = accept && (burst_cnt_q == 8'(MAX_BURST - 1));
        release_d = (state_q == BURST) && (!owner_req || last_word);
        scan_base = (state_q == BURST) ? owner_q : last_q;
    end

    // Round-robin pick: first requester after scan_base, wrapping; scanning
    // farthest-first lets the nearest match overwrite and win.
    always_comb begin
        winner_d = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i == (int'(scan_base) + k) % N)) begin
                    winner_d = 3'(i);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            win_oh_d[i] = (winner_d == 3'(i));
        end
    end

    // Write-data mux selected by the one-hot grant.
    always_comb begin
        fifo_w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                fifo_w_data = data_in[i*B +: B];
            end
        end
    end

    assign fifo_wr = accept;
    assign ack     = accept ? gnt_q : '0;
    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = (state_q == BURST);
    assign ovf_err = ovf_q;

    // Grant FSM: hand-over on release happens in the same edge (no idle bubble).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            last_q      <= 3'(N - 1);
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q     <= BURST;
                        gnt_q       <= win_oh_d;
                        owner_q     <= winner_d;
                        burst_cnt_q <= '0;
                    end
                end
                BURST: begin
                    if (release_d) begin
                        last_q      <= owner_q;
                        burst_cnt_q <= '0;
                        if (|req) begin
                            gnt_q   <= win_oh_d;
                            owner_q <= winner_d;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (accept) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (fifo_of) begin
            ovf_q <= 1'b1;
        end else if (clr_err) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the owner wanted to write but the fifo was full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (clr_err) begin
            stall_q <= '0;
        end else if ((state_q == BURST) && owner_req && fifo_full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int B = 8;
    localparam int N = 4;
    localparam int MAXB = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*B-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic           fifo_full;
    logic           fifo_of;
    logic           clr_err;
    logic           ovf_err;
    logic [2:0]     owner;
    logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]    stall_cnt;
`endif

    fifo_wr_arbiter #(.B(B), .N(N), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt), .ack(ack), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data),
        .fifo_full(fifo_full), .fifo_of(fifo_of), .clr_err(clr_err),
        .ovf_err(ovf_err), .owner(owner), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Behavioural reference: who holds the grant, how many words it has taken,
    // who held it last, and the error/stat registers.
    int   m_busy, m_owner, m_last, m_cnt, m_stall;
    bit   m_ovf;

    function automatic int rr_next(input logic [N-1:0] r, input int base);
        for (int k = 1; k <= N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_stall = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = (m_busy != 0) && req[m_owner] && !fifo_full;
        if (clr_err) m_stall = 0;
        else if (m_busy != 0 && req[m_owner] && fifo_full && m_stall < 65535) m_stall++;
        if (fifo_of) m_ovf = 1;
        else if (clr_err) m_ovf = 0;
        if (m_busy != 0) begin
            if (!req[m_owner] || (acc && m_cnt == MAXB - 1)) begin
                m_last = m_owner;
                m_cnt = 0;
                if (req != 0) m_owner = rr_next(req, m_owner);
                else m_busy = 0;
            end else if (acc) begin
                m_cnt++;
            end
        end else if (req != 0) begin
            m_owner = rr_next(req, m_last);
            m_busy = 1;
            m_cnt = 0;
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        bit acc;
        acc = (m_busy != 0) && req[m_owner] && !fifo_full;
        eg = (m_busy != 0) ? (N'(1) << m_owner) : '0;
        chk("rnd_gnt", 32'(gnt), 32'(eg));
        chk("rnd_wr", 32'(fifo_wr), 32'(acc));
        chk("rnd_ack", 32'(ack), acc ? 32'(eg) : 32'd0);
        chk("rnd_busy", 32'(busy), 32'(m_busy != 0));
        chk("rnd_ovf", 32'(ovf_err), 32'(m_ovf));
        if (m_busy != 0) begin
            chk("rnd_owner", 32'(owner), 32'(m_owner));
            chk("rnd_data", 32'(fifo_w_data), 32'(data_in[m_owner*B +: B]));
        end
`ifdef FIFO_WR_ARB_STATS_EN
        chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; fifo_full = 1'b0; fifo_of = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic         of;
        logic         clr;
        logic [N-1:0] gnt;
        logic         wr;
        logic         ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [N-1:0] eg;
        logic [B-1:0] ed;
        int wcnt;

        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[4]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[6]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[7]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[9]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[15] = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[18] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[19] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0};

        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();

        // Post-reset state
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        @(posedge clk); #1;

        // Directed vector table
        for (int r = 0; r < 20; r++) begin
            req = tbl[r].req; fifo_full = tbl[r].full;
            fifo_of = tbl[r].of; clr_err = tbl[r].clr;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
            chk($sformatf("tbl%0d_wr", r), 32'(fifo_wr), 32'(tbl[r].wr));
            chk($sformatf("tbl%0d_ack", r), 32'(ack), tbl[r].wr ? 32'(tbl[r].gnt) : 32'd0);
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].gnt != 0));
            chk($sformatf("tbl%0d_ovf", r), 32'(ovf_err), 32'(tbl[r].ovf));
            if (tbl[r].wr) begin
                ed = '0;
                for (int i = 0; i < N; i++) if (tbl[r].gnt[i]) ed = data_in[i*B +: B];
                chk($sformatf("tbl%0d_data", r), 32'(fifo_w_data), 32'(ed));
            end
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-burst, with ovf_err set beforehand
        req = 4'b1000; fifo_full = 1'b0; clr_err = 1'b0; fifo_of = 1'b1;
        @(posedge clk); #1 fifo_of = 1'b0;
        @(negedge clk);
        chk("ar_pre_ovf", 32'(ovf_err), 32'd1);
        chk("ar_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_wr", 32'(fifo_wr), 32'd0);
        chk("ar_ovf", 32'(ovf_err), 32'd0);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("ar_rel_gnt", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_first_gnt", 32'(gnt), 32'b1000);
        chk("ar_first_owner", 32'(owner), 32'd3);
        chk("ar_first_wr", 32'(fifo_wr), 32'd1);

        // Full stall while requester 2 owns the grant
        do_reset();
        req = 4'b0100;
        @(posedge clk); #1;
        wcnt = 0;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 1 && c <= 5);
            @(negedge clk);
            chk($sformatf("st%0d_gnt", c), 32'(gnt), 32'b0100);
            chk($sformatf("st%0d_wr", c), 32'(fifo_wr), 32'(!(c >= 1 && c <= 5)));
            chk($sformatf("st%0d_ack", c), 32'(ack), (c >= 1 && c <= 5) ? 32'd0 : 32'b0100);
            if (fifo_wr) wcnt++;
            @(posedge clk); #1;
        end
        fifo_full = 1'b0; req = '0;
        chk("st_words", 32'(wcnt), 32'd4);
`ifdef FIFO_WR_ARB_STATS_EN
        @(negedge clk);
        chk("st_stall_cnt", 32'(stall_cnt), 32'd5);
        @(posedge clk); #1;
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 15));
            fifo_full = ($urandom_range(0, 3) == 0);
            fifo_of   = ($urandom_range(0, 49) == 0);
            clr_err   = ($urandom_range(0, 39) == 0);
            data_in   = $urandom;
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
